game_sequencer: RTL and testbench
=================================

GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 SHALL have parameter MAX_ROUNDS, default 8: number of guesses allowed per game (legal range 1..15).
REQ-002 SHALL have port clock, input, 1: the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_L, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port startGame, input, 1: request to begin a new game.
REQ-005 SHALL have port loadShape, input, 3: shape code for a master-pattern slot.
REQ-006 SHALL have port shapeLocation, input, 2: slot index 0..3.
REQ-007 SHALL have port loadStrobe, input, 1: writes loadShape into the slot selected by shapeLocation this cycle.
REQ-008 SHALL have port gradeIt, input, 1: player has submitted a guess for grading.
REQ-009 SHALL have ports ZnarlyCount (input, 4), ZoodCount (input, 4) and GameWon (input, 1): results from the guess grader.
REQ-010 SHALL have port masterPattern, output, 12: master pattern; slot n occupies bits [3n+2:3n].
REQ-011 SHALL have ports loadingShape, ongoingGame, areRoundsLeft and doneGrading, outputs, 1 each: controls driven to the grader.
REQ-012 SHALL have port roundNumber, output, 4: count of guesses graded in the current game.
REQ-013 SHALL have ports lastZnarly and lastZood, outputs, 4 each: latched result of the most recent grade.
REQ-014 SHALL have ports gameOver and won, outputs, 1 each: end-of-game status.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, PLAY, GRADE, WON, LOST.
REQ-016 SHALL leave IDLE, WON or LOST for LOAD when startGame=1; entering LOAD clears masterPattern, the slot-loaded mask, roundNumber, lastZnarly, lastZood and won.
REQ-017 SHALL ignore startGame in LOAD, PLAY and GRADE.
REQ-018 SHALL treat shape codes 3'b001..3'b110 (T,C,O,D,I,Z) as valid; loadStrobe with 3'b000 or 3'b111 changes nothing.
REQ-019 SHALL, in LOAD, write a valid loadStrobe into its slot and set that slot's mask bit; rewriting an already-loaded slot overwrites it.
REQ-020 SHALL move LOAD->PLAY on the first clock edge at which the mask is 4'hF; loadStrobe in PLAY or later is ignored.
REQ-021 SHALL assert loadingShape=1 only in LOAD, and ongoingGame=1 only in PLAY and GRADE.
REQ-022 SHALL move PLAY->GRADE on gradeIt=1 and ignore gradeIt in every other state.
REQ-023 SHALL make GRADE last exactly one cycle with doneGrading=1, sampling ZnarlyCount, ZoodCount and GameWon at its closing edge into lastZnarly and lastZood, and incrementing roundNumber.
REQ-024 SHALL leave GRADE for WON if GameWon=1; otherwise for LOST if roundNumber+1==MAX_ROUNDS; otherwise for PLAY.
REQ-025 SHALL make a win on the final round go to WON, not LOST.
REQ-026 SHALL drive areRoundsLeft = (roundNumber < MAX_ROUNDS), compared at 4-bit width.
REQ-027 SHALL assert gameOver=1 in WON and LOST, won=1 only in WON, and hold masterPattern and last results stable in WON and LOST.

Reset
REQ-028 SHALL, while reset_L=0, immediately force state IDLE and drive every output to 0 (masterPattern 12'h000, roundNumber 0, all flags 0), including when reset arrives mid-LOAD or mid-GRADE.
REQ-029 SHALL, after reset_L deasserts, take no action until startGame=1.

Structure
REQ-030 SHALL take the shape_t enum (3-bit shape codes), the state_t enum and the default MAX_ROUNDS from a shared package, game_pkg.
REQ-031 SHALL place the slot register and loaded mask in one sub-module, pattern_loader, with controls clear and enable; the FSM and the round counter stay in game_sequencer.

Verification
REQ-032 SHALL cover: reset, then startGame, then loads (loc0,T)(loc1,C)(loc2,O)(loc3,D) -> masterPattern=12'b100_011_010_001 and PLAY one cycle after the fourth load.
REQ-033 SHALL cover: in LOAD, loadShape=3'b111 at loc2 -> mask unchanged and no exit from LOAD.
REQ-034 SHALL cover: gradeIt with Znarly=2, Zood=1, GameWon=0 -> doneGrading high for one cycle, lastZnarly=2, lastZood=1, roundNumber=1, back to PLAY.
REQ-035 SHALL cover: 8 non-winning grades with MAX_ROUNDS=8 -> LOST, gameOver=1, won=0, areRoundsLeft=0.
REQ-036 SHALL cover: GameWon=1 on round 8 -> WON with won=1; then startGame -> LOAD with masterPattern=0 and roundNumber=0.
REQ-037 SHALL cover: reset_L pulsed low in GRADE -> outputs 0 asynchronously, state IDLE.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and defaults for the game sequencer and its pattern loader.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package game_pkg;

    // 3-bit shape codes; NONE and BAD are the two unused encodings.
    typedef enum logic [2:0] {
        SHAPE_NONE = 3'b000,
        SHAPE_T    = 3'b001,
        SHAPE_C    = 3'b010,
        SHAPE_O    = 3'b011,
        SHAPE_D    = 3'b100,
        SHAPE_I    = 3'b101,
        SHAPE_Z    = 3'b110,
        SHAPE_BAD  = 3'b111
    } shape_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        PLAY  = 3'd2,
        GRADE = 3'd3,
        WON   = 3'd4,
        LOST  = 3'd5
    } state_t;

    localparam int DEFAULT_MAX_ROUNDS = 8;

    // Only the six real shapes may be stored in a slot.
    function automatic logic shape_is_valid(input shape_t s);
        return (s != SHAPE_NONE) && (s != SHAPE_BAD);
    endfunction

endpackage

// File: rtl/pattern_loader.sv
// Master-pattern slot register plus per-slot loaded mask.
// Latency: a write is visible on pattern/mask one cycle after enable.
// Backpressure: none; invalid shape codes are dropped silently.
module pattern_loader
    import game_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        enable,
    input  logic [1:0]  slot,
    input  shape_t      shape,
    output logic [11:0] pattern,
    output logic [3:0]  mask
);

    logic [11:0] pattern_q, pattern_d;
    logic [3:0]  mask_q, mask_d;

    // Clear wins over a write; a valid write overwrites the slot and marks it loaded.
    always_comb begin
        pattern_d = pattern_q;
        mask_d    = mask_q;
        if (clear) begin
            pattern_d = '0;
            mask_d    = '0;
        end else if (enable && shape_is_valid(shape)) begin
            case (slot)
                2'd0:    pattern_d[2:0]   = shape;
                2'd1:    pattern_d[5:3]   = shape;
                2'd2:    pattern_d[8:6]   = shape;
                default: pattern_d[11:9]  = shape;
            endcase
            mask_d[slot] = 1'b1;
        end
    end

    // Slot and mask registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern_q <= '0;
            mask_q    <= '0;
        end else begin
            pattern_q <= pattern_d;
            mask_q    <= mask_d;
        end
    end

    assign pattern = pattern_q;
    assign mask    = mask_q;

endmodule

// File: rtl/game_sequencer.sv
// Game controller: pattern loading, round play, one-cycle grading, win/lose status.
// Latency: LOAD->PLAY one edge after the mask fills; GRADE lasts exactly one cycle.
// Backpressure: none; requests outside their accepting state are ignored.
module game_sequencer
    import game_pkg::*;
#(
    parameter int MAX_ROUNDS = DEFAULT_MAX_ROUNDS
) (
    input  logic        clock,
    input  logic        reset_L,
    input  logic        startGame,
    input  logic [2:0]  loadShape,
    input  logic [1:0]  shapeLocation,
    input  logic        loadStrobe,
    input  logic        gradeIt,
    input  logic [3:0]  ZnarlyCount,
    input  logic [3:0]  ZoodCount,
    input  logic        GameWon,
    output logic [11:0] masterPattern,
    output logic        loadingShape,
    output logic        ongoingGame,
    output logic        areRoundsLeft,
    output logic        doneGrading,
    output logic [3:0]  roundNumber,
    output logic [3:0]  lastZnarly,
    output logic [3:0]  lastZood,
    output logic        gameOver,
    output logic        won
);

    localparam logic [3:0] MAX_R = 4'(MAX_ROUNDS);

    state_t     state_q, state_d;
    logic [3:0] round_q, round_d;
    logic [3:0] last_znarly_q, last_znarly_d;
    logic [3:0] last_zood_q, last_zood_d;
    logic       loader_clear;
    logic       loader_en;
    logic [3:0] slot_mask;

    pattern_loader u_loader (
        .clk     (clock),
        .rst_n   (reset_L),
        .clear   (loader_clear),
        .enable  (loader_en),
        .slot    (shapeLocation),
        .shape   (shape_t'(loadShape)),
        .pattern (masterPattern),
        .mask    (slot_mask)
    );

    // Next-state, round counter and grade-result latching.
    always_comb begin
        state_d       = state_q;
        round_d       = round_q;
        last_znarly_d = last_znarly_q;
        last_zood_d   = last_zood_q;
        loader_clear  = 1'b0;
        loader_en     = 1'b0;
        case (state_q)
            IDLE, WON, LOST: begin
                if (startGame) begin
                    state_d       = LOAD;
                    loader_clear  = 1'b1;
                    round_d       = '0;
                    last_znarly_d = '0;
                    last_zood_d   = '0;
                end
            end
            LOAD: begin
                // The mask is registered, so the exit happens on the edge after
                // the fourth distinct slot lands; a strobe on that edge still writes.
                loader_en = loadStrobe;
                if (slot_mask == 4'hF) state_d = PLAY;
            end
            PLAY: begin
                if (gradeIt) state_d = GRADE;
            end
            GRADE: begin
                last_znarly_d = ZnarlyCount;
                last_zood_d   = ZoodCount;
                round_d       = round_q + 4'd1;
                // A win on the final round must still count as a win.
                if (GameWon)               state_d = WON;
                else if (round_d == MAX_R) state_d = LOST;
                else                       state_d = PLAY;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, round and result registers.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state_q       <= IDLE;
            round_q       <= '0;
            last_znarly_q <= '0;
            last_zood_q   <= '0;
        end else begin
            state_q       <= state_d;
            round_q       <= round_d;
            last_znarly_q <= last_znarly_d;
            last_zood_q   <= last_zood_d;
        end
    end

    assign loadingShape  = (state_q == LOAD);
    assign ongoingGame   = (state_q == PLAY) || (state_q == GRADE);
    assign doneGrading   = (state_q == GRADE);
    assign gameOver      = (state_q == WON) || (state_q == LOST);
    assign won           = (state_q == WON);
    assign roundNumber   = round_q;
    assign lastZnarly    = last_znarly_q;
    assign lastZood      = last_zood_q;
    // Gated by reset so every output reads zero while reset is held.
    assign areRoundsLeft = reset_L && (round_q < MAX_R);

endmodule

// File: tb/tb_game_sequencer.sv
module tb_game_sequencer;

    localparam int MAXR = 8;

    logic        clock = 1'b0;
    logic        reset_L = 1'b0;
    logic        startGame = 1'b0;
    logic [2:0]  loadShape = '0;
    logic [1:0]  shapeLocation = '0;
    logic        loadStrobe = 1'b0;
    logic        gradeIt = 1'b0;
    logic [3:0]  ZnarlyCount = '0;
    logic [3:0]  ZoodCount = '0;
    logic        GameWon = 1'b0;
    logic [11:0] masterPattern;
    logic        loadingShape, ongoingGame, areRoundsLeft, doneGrading;
    logic [3:0]  roundNumber, lastZnarly, lastZood;
    logic        gameOver, won;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: slot contents, which slots are filled, whether the game is loading,
    // rounds used and the last grade seen.
    int m_slot[4];
    bit m_loaded[4];
    bit m_in_load;
    int m_round;
    int m_zn;
    int m_zo;

    game_sequencer #(.MAX_ROUNDS(MAXR)) dut (
        .clock(clock), .reset_L(reset_L), .startGame(startGame), .loadShape(loadShape),
        .shapeLocation(shapeLocation), .loadStrobe(loadStrobe), .gradeIt(gradeIt),
        .ZnarlyCount(ZnarlyCount), .ZoodCount(ZoodCount), .GameWon(GameWon),
        .masterPattern(masterPattern), .loadingShape(loadingShape), .ongoingGame(ongoingGame),
        .areRoundsLeft(areRoundsLeft), .doneGrading(doneGrading), .roundNumber(roundNumber),
        .lastZnarly(lastZnarly), .lastZood(lastZood), .gameOver(gameOver), .won(won)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [11:0] model_pattern();
        logic [11:0] p = '0;
        for (int i = 0; i < 4; i++) p = p | (12'(m_slot[i]) << (3 * i));
        return p;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic quiet();
        startGame = 0; loadStrobe = 0; gradeIt = 0; loadShape = 0; shapeLocation = 0;
        ZnarlyCount = 0; ZoodCount = 0; GameWon = 0;
    endtask

    task automatic model_new_game();
        for (int i = 0; i < 4; i++) begin m_slot[i] = 0; m_loaded[i] = 0; end
        m_in_load = 1; m_round = 0; m_zn = 0; m_zo = 0;
    endtask

    // Start a game from IDLE/WON/LOST and check that everything was cleared.
    task automatic start_game();
        startGame = 1; tick(); startGame = 0;
        model_new_game();
        n_cmp++;
        if (loadingShape !== 1'b1 || masterPattern !== 12'h000 || roundNumber !== 4'd0 ||
            lastZnarly !== 4'd0 || lastZood !== 4'd0 || gameOver !== 1'b0 || won !== 1'b0) begin
            n_bad++;
            $display("FAIL start_clear: load=%b pat=%h rnd=%0d zn=%0d zo=%0d over=%b won=%b required load=1 rest 0",
                     loadingShape, masterPattern, roundNumber, lastZnarly, lastZood, gameOver, won);
        end
    endtask

    // One cycle of load-phase stimulus, predicted from the loading rules.
    task automatic load_cycle(input bit stb, input int loc, input int shp);
        bit leaving;
        leaving = m_loaded[0] && m_loaded[1] && m_loaded[2] && m_loaded[3];
        loadStrobe = stb; shapeLocation = 2'(loc); loadShape = 3'(shp);
        if (m_in_load) begin
            if (stb && shp >= 1 && shp <= 6) begin m_slot[loc] = shp; m_loaded[loc] = 1; end
            if (leaving) m_in_load = 0;
        end
        tick();
        loadStrobe = 0;
        n_cmp++;
        if (masterPattern !== model_pattern() || loadingShape !== m_in_load || ongoingGame !== !m_in_load) begin
            n_bad++;
            $display("FAIL load_cycle: pat=%h load=%b ongoing=%b required pat=%h load=%b ongoing=%b",
                     masterPattern, loadingShape, ongoingGame, model_pattern(), m_in_load, !m_in_load);
        end
    endtask

    task automatic start_and_load();
        int waited;
        start_game();
        for (int i = 0; i < 4; i++) load_cycle(1'b1, i, $urandom_range(1, 6));
        waited = 0;
        while (m_in_load && waited < 10) begin load_cycle(1'b0, 0, 0); waited++; end
        n_cmp++;
        if (ongoingGame !== 1'b1) begin
            n_bad++;
            $display("FAIL start_and_load: ongoingGame=%b required 1", ongoingGame);
        end
    endtask

    // Submit a guess from PLAY; grader results are only presented during the GRADE cycle.
    task automatic grade(input int zn, input int zo, input bit gw);
        gradeIt = 1; ZnarlyCount = 4'($urandom); ZoodCount = 4'($urandom); GameWon = 1'($urandom);
        tick();
        gradeIt = 1'($urandom); ZnarlyCount = 4'(zn); ZoodCount = 4'(zo); GameWon = gw;
        tick();
        gradeIt = 0; GameWon = 0; ZnarlyCount = 0; ZoodCount = 0;
    endtask

    task automatic test_reset();
        quiet();
        reset_L = 0;
        #3;
        n_cmp++;
        if ({masterPattern, roundNumber, lastZnarly, lastZood, loadingShape, ongoingGame,
             areRoundsLeft, doneGrading, gameOver, won} !== 34'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: pat=%h rnd=%0d arl=%b over=%b required all 0",
                     masterPattern, roundNumber, areRoundsLeft, gameOver);
        end
        tick(); tick();
        @(negedge clock); reset_L = 1;
        for (int i = 0; i < 5; i++) begin
            loadStrobe = 1'($urandom); gradeIt = 1'($urandom);
            loadShape = 3'($urandom_range(1, 6)); shapeLocation = 2'($urandom);
            tick();
            n_cmp++;
            if (loadingShape !== 1'b0 || ongoingGame !== 1'b0 || gameOver !== 1'b0 ||
                masterPattern !== 12'h000 || roundNumber !== 4'd0) begin
                n_bad++;
                $display("FAIL idle_no_action: load=%b ongoing=%b over=%b pat=%h rnd=%0d required 0",
                         loadingShape, ongoingGame, gameOver, masterPattern, roundNumber);
            end
        end
        quiet();
    endtask

    task automatic test_load_directed();
        start_game();
        for (int i = 0; i < 4; i++) begin
            loadShape = 3'(i + 1); shapeLocation = 2'(i); loadStrobe = 1;
            tick();
        end
        loadStrobe = 0;
        n_cmp++;
        if (masterPattern !== 12'b100_011_010_001 || loadingShape !== 1'b1) begin
            n_bad++;
            $display("FAIL load_directed: pat=%b load=%b required 100011010001 load=1", masterPattern, loadingShape);
        end
        tick();
        n_cmp++;
        if (ongoingGame !== 1'b1 || loadingShape !== 1'b0 || roundNumber !== 4'd0 || areRoundsLeft !== 1'b1) begin
            n_bad++;
            $display("FAIL enter_play: ongoing=%b load=%b rnd=%0d arl=%b required 1 0 0 1",
                     ongoingGame, loadingShape, roundNumber, areRoundsLeft);
        end
        m_in_load = 0;
        for (int i = 0; i < 4; i++) begin m_slot[i] = i + 1; m_loaded[i] = 1; end
        // Loads and start requests during PLAY are ignored.
        startGame = 1;
        load_cycle(1'b1, 0, 6);
        startGame = 0;
    endtask

    task automatic test_grade();
        gradeIt = 1; ZnarlyCount = 4'd9; ZoodCount = 4'd9; GameWon = 1;
        tick();
        gradeIt = 0; ZnarlyCount = 4'd2; ZoodCount = 4'd1; GameWon = 0;
        n_cmp++;
        if (doneGrading !== 1'b1 || ongoingGame !== 1'b1 || roundNumber !== 4'd0) begin
            n_bad++;
            $display("FAIL grade_cycle: done=%b ongoing=%b rnd=%0d required 1 1 0", doneGrading, ongoingGame, roundNumber);
        end
        tick();
        ZnarlyCount = 0; ZoodCount = 0;
        m_round = 1; m_zn = 2; m_zo = 1;
        n_cmp++;
        if (doneGrading !== 1'b0 || lastZnarly !== 4'd2 || lastZood !== 4'd1 || roundNumber !== 4'd1 ||
            ongoingGame !== 1'b1 || gameOver !== 1'b0) begin
            n_bad++;
            $display("FAIL grade_result: done=%b zn=%0d zo=%0d rnd=%0d ongoing=%b over=%b required 0 2 1 1 1 0",
                     doneGrading, lastZnarly, lastZood, roundNumber, ongoingGame, gameOver);
        end
    endtask

    task automatic test_lose();
        int zn, zo;
        while (m_round < MAXR) begin
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                startGame = 1'($urandom); GameWon = 1'($urandom); loadStrobe = 1'($urandom);
                loadShape = 3'($urandom_range(1, 6)); shapeLocation = 2'($urandom);
                tick();
                quiet();
                n_cmp++;
                if (roundNumber !== 4'(m_round) || ongoingGame !== 1'b1 || doneGrading !== 1'b0 ||
                    masterPattern !== model_pattern()) begin
                    n_bad++;
                    $display("FAIL play_idle: rnd=%0d ongoing=%b done=%b pat=%h required rnd=%0d 1 0 pat=%h",
                             roundNumber, ongoingGame, doneGrading, masterPattern, m_round, model_pattern());
                end
            end
            zn = $urandom_range(0, 15); zo = $urandom_range(0, 15);
            grade(zn, zo, 1'b0);
            m_round++; m_zn = zn; m_zo = zo;
            n_cmp++;
            if (roundNumber !== 4'(m_round) || lastZnarly !== 4'(m_zn) || lastZood !== 4'(m_zo) ||
                gameOver !== (m_round == MAXR) || ongoingGame !== (m_round != MAXR) ||
                areRoundsLeft !== (m_round < MAXR) || won !== 1'b0) begin
                n_bad++;
                $display("FAIL lose_round: rnd=%0d zn=%0d zo=%0d over=%b ongoing=%b arl=%b won=%b required rnd=%0d zn=%0d zo=%0d",
                         roundNumber, lastZnarly, lastZood, gameOver, ongoingGame, areRoundsLeft, won,
                         m_round, m_zn, m_zo);
            end
        end
        // LOST holds: grading and loading are ignored.
        for (int i = 0; i < 3; i++) begin
            gradeIt = 1; GameWon = 1; loadStrobe = 1; loadShape = 3'd5; shapeLocation = 2'($urandom);
            tick();
            quiet();
            n_cmp++;
            if (gameOver !== 1'b1 || won !== 1'b0 || roundNumber !== 4'(MAXR) || lastZnarly !== 4'(m_zn) ||
                lastZood !== 4'(m_zo) || masterPattern !== model_pattern()) begin
                n_bad++;
                $display("FAIL lost_hold: over=%b won=%b rnd=%0d zn=%0d zo=%0d pat=%h required 1 0 %0d %0d %0d %h",
                         gameOver, won, roundNumber, lastZnarly, lastZood, masterPattern,
                         MAXR, m_zn, m_zo, model_pattern());
            end
        end
    endtask

    task automatic test_invalid_shape();
        int waited;
        start_game();
        load_cycle(1'b1, 0, 1);
        load_cycle(1'b1, 1, 2);
        load_cycle(1'b1, 3, 4);
        load_cycle(1'b1, 2, 7);
        load_cycle(1'b0, 0, 0);
        load_cycle(1'b0, 0, 0);
        load_cycle(1'b1, 2, 0);
        load_cycle(1'b0, 0, 0);
        for (int i = 0; i < 20 && m_in_load; i++)
            load_cycle(1'($urandom), $urandom_range(0, 3), $urandom_range(0, 7));
        waited = 0;
        while (m_in_load && waited < 10) begin
            load_cycle(1'b1, 2, $urandom_range(1, 6));
            waited++;
        end
        load_cycle(1'b1, $urandom_range(0, 3), $urandom_range(1, 6));
        n_cmp++;
        if (ongoingGame !== 1'b1) begin
            n_bad++;
            $display("FAIL invalid_exit: ongoingGame=%b required 1", ongoingGame);
        end
    endtask

    task automatic test_win_early();
        int r;
        r = $urandom_range(1, MAXR - 1);
        for (int i = 1; i < r; i++) grade($urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
        grade(4, 0, 1'b1);
        n_cmp++;
        if (won !== 1'b1 || gameOver !== 1'b1 || ongoingGame !== 1'b0 || roundNumber !== 4'(r) ||
            areRoundsLeft !== 1'b1 || lastZnarly !== 4'd4 || lastZood !== 4'd0) begin
            n_bad++;
            $display("FAIL win_early: won=%b over=%b ongoing=%b rnd=%0d arl=%b zn=%0d required 1 1 0 %0d 1 4",
                     won, gameOver, ongoingGame, roundNumber, areRoundsLeft, lastZnarly, r);
        end
        gradeIt = 1; tick(); quiet();
        n_cmp++;
        if (won !== 1'b1 || roundNumber !== 4'(r)) begin
            n_bad++;
            $display("FAIL won_hold: won=%b rnd=%0d required 1 %0d", won, roundNumber, r);
        end
    endtask

    task automatic test_win_last();
        start_and_load();
        for (int i = 1; i < MAXR; i++) grade($urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
        n_cmp++;
        if (roundNumber !== 4'(MAXR - 1) || ongoingGame !== 1'b1) begin
            n_bad++;
            $display("FAIL before_last: rnd=%0d ongoing=%b required %0d 1", roundNumber, ongoingGame, MAXR - 1);
        end
        grade(4, 0, 1'b1);
        n_cmp++;
        if (won !== 1'b1 || gameOver !== 1'b1 || roundNumber !== 4'(MAXR) || areRoundsLeft !== 1'b0) begin
            n_bad++;
            $display("FAIL win_last: won=%b over=%b rnd=%0d arl=%b required 1 1 %0d 0",
                     won, gameOver, roundNumber, areRoundsLeft, MAXR);
        end
        start_game();
    endtask

    task automatic test_reset_midway();
        load_cycle(1'b1, 1, 3);
        #2 reset_L = 0;
        #1;
        n_cmp++;
        if ({masterPattern, roundNumber, loadingShape, ongoingGame, areRoundsLeft, gameOver} !== 20'h0) begin
            n_bad++;
            $display("FAIL reset_in_load: pat=%h rnd=%0d load=%b required 0", masterPattern, roundNumber, loadingShape);
        end
        @(negedge clock); reset_L = 1;
        tick();
        n_cmp++;
        if (loadingShape !== 1'b0 || masterPattern !== 12'h000) begin
            n_bad++;
            $display("FAIL idle_after_reset: load=%b pat=%h required 0 0", loadingShape, masterPattern);
        end
        start_and_load();
        grade(1, 1, 1'b0);
        gradeIt = 1; ZnarlyCount = 4'd7; ZoodCount = 4'd3;
        tick();
        gradeIt = 0;
        n_cmp++;
        if (doneGrading !== 1'b1) begin
            n_bad++;
            $display("FAIL reach_grade: doneGrading=%b required 1", doneGrading);
        end
        #2 reset_L = 0;
        #1;
        n_cmp++;
        if ({masterPattern, roundNumber, lastZnarly, lastZood, loadingShape, ongoingGame,
             areRoundsLeft, doneGrading, gameOver, won} !== 34'h0) begin
            n_bad++;
            $display("FAIL reset_in_grade: pat=%h rnd=%0d zn=%0d done=%b ongoing=%b required all 0",
                     masterPattern, roundNumber, lastZnarly, doneGrading, ongoingGame);
        end
        tick();
        @(negedge clock); reset_L = 1;
        quiet();
        gradeIt = 1;
        tick();
        gradeIt = 0;
        n_cmp++;
        if (doneGrading !== 1'b0 || ongoingGame !== 1'b0 || loadingShape !== 1'b0 ||
            roundNumber !== 4'd0 || lastZnarly !== 4'd0) begin
            n_bad++;
            $display("FAIL idle_after_grade_reset: done=%b ongoing=%b load=%b rnd=%0d zn=%0d required all 0",
                     doneGrading, ongoingGame, loadingShape, roundNumber, lastZnarly);
        end
    endtask

    initial begin
        test_reset();
        test_load_directed();
        test_grade();
        test_lose();
        test_invalid_shape();
        m_round = 0;
        test_win_early();
        test_win_last();
        test_reset_midway();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
